uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 39 +++
 rtl/uart_tx_fifo.sv | 146 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// ============================================================================
// Module      : uart_tx_fifo_if
// Description : Bundle of the write port, status flags and downstream
//               transmitter handshake of uart_tx_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    wr_data;
  logic          wr_en;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          ovf_clr;
  logic [7:0]    txbyte;
  logic          senddata;
  logic          txdone;
  logic          tx_err;

  // FIFO side: consumes writes and transmitter completions, reports status
  modport slave (
    input  wr_data, wr_en, ovf_clr, txdone,
    output full, empty, count, overflow, txbyte, senddata, tx_err
  );

  // Producer / transmitter side
  modport master (
    output wr_data, wr_en, ovf_clr, txdone,
    input  full, empty, count, overflow, txbyte, senddata, tx_err
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO feeding an 8N1 transmitter. A three-state sender
//               pops one byte at a time, fires a one-cycle senddata trigger
//               and waits (bounded by TIMEOUT) for the txdone pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_fifo_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [7:0]    txbyte_q, txbyte_d;
  logic          txerr_q, txerr_d;
  logic          w_push;
  logic          w_pop;

  // Space is judged on the registered full flag only, so a pop in the same
  // cycle never makes room for a write. The sender pops only from IDLE.
  assign w_push = bus.wr_en & ~full_q;
  assign w_pop  = (state_q == IDLE) & ~empty_q;

  // FIFO pointer, occupancy and sticky-overflow next state
  always_comb begin
    wr_ptr_d = w_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + CW'(1);
    end else if (w_pop && !w_push) begin
      count_d = count_q - CW'(1);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
    // A dropped write wins over a clear in the same cycle
    if (bus.wr_en && full_q) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Sender FSM: IDLE pops, SEND triggers for one cycle, WAIT awaits txdone
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    txbyte_d = txbyte_q;
    txerr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          txbyte_d = mem_q[rd_ptr_q];
          state_d  = SEND;
        end
      end
      SEND: begin
        state_d = WAIT;
        tmr_d   = '0;
      end
      WAIT: begin
        if (bus.txdone) begin
          state_d = IDLE;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          // TIMEOUT cycles spent in WAIT: give up on this byte
          state_d = IDLE;
          txerr_d = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Storage array; contents need no reset because pointers/count gate reads
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  // Control and status registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      state_q  <= IDLE;
      tmr_q    <= '0;
      txbyte_q <= '0;
      txerr_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      txbyte_q <= txbyte_d;
      txerr_q  <= txerr_d;
    end
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
  assign bus.txbyte   = txbyte_q;
  assign bus.senddata = (state_q == SEND);
  assign bus.tx_err   = txerr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo. Stimulus queues the
//               bytes it expects to see on txbyte; a monitor pops and
//               compares on every senddata pulse. A responder model returns
//               txdone a programmable number of cycles after each trigger.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] exp_q [$];

  logic done_resp  = 1'b0;
  logic done_force = 1'b0;
  assign bus.txdone = done_resp | done_force;

  int resp_dly  = 12;
  int skip_n    = 0;
  int last_done = -1;
  int last_send = -1;
  int sends     = 0;
  int errs      = 0;
  bit gap_chk   = 1'b0;
  bit cnt_chk   = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard: observes the DUT on the falling edge
  always @(negedge clk) begin
    if (bus.txdone) last_done = cyc;
    if (bus.senddata) begin
      sends++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_send: got txbyte %0h expected no send (cycle %0d)", bus.txbyte, cyc);
      end else begin
        chk("txbyte_order", bus.txbyte, exp_q.pop_front());
      end
      if (gap_chk && last_done >= 0) chk("done_to_send_gap", cyc - last_done, 2);
      last_send = cyc;
    end
    if (bus.tx_err) begin
      errs++;
      // WAIT entered one edge after SEND, error flagged TIMEOUT edges later
      chk("timeout_latency", cyc - last_send, TIMEOUT + 1);
    end
    if (cnt_chk) begin
      chk("count_le_depth", (bus.count <= DEPTH), 1);
      chk("full_vs_count",  bus.full,  (bus.count == DEPTH));
      chk("empty_vs_count", bus.empty, (bus.count == 0));
    end
  end

  // Downstream transmitter model
  always begin
    @(negedge clk);
    if (bus.senddata) begin
      if (skip_n > 0) begin
        skip_n--;
      end else begin
        repeat (resp_dly) @(posedge clk);
        #1 done_resp = 1'b1;
        @(posedge clk);
        #1 done_resp = 1'b0;
      end
    end
  end

  task automatic put(input logic [7:0] b, input bit acc);
    @(posedge clk);
    #1;
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    if (acc) exp_q.push_back(b);
  endtask

  task automatic idle();
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || !bus.empty) && k < 3000) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain_in_time", (k < 3000), 1);
    cycles(resp_dly + 6);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sends_before;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.ovf_clr = 1'b0;

    // Reset values
    rst_n = 1'b0;
    cycles(3);
    chk("rst_count",    bus.count,    0);
    chk("rst_empty",    bus.empty,    1);
    chk("rst_full",     bus.full,     0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_txbyte",   bus.txbyte,   0);
    chk("rst_senddata", bus.senddata, 0);
    chk("rst_tx_err",   bus.tx_err,   0);
    rst_n = 1'b1;
    cycles(3);
    chk("no_send_after_reset", sends, 0);

    // Single byte latency
    put(8'hA5, 1'b1);
    idle();
    chk("empty_after_write", bus.empty, 0);
    chk("count_after_write", bus.count, 1);
    cycles(1);
    chk("send_latency",   bus.senddata, 1);
    chk("single_txbyte",  bus.txbyte,   8'hA5);
    chk("empty_after_pop", bus.empty,   1);
    cycles(14);
    chk("single_sends",    sends,        1);
    chk("single_idle",     bus.senddata, 0);
    chk("single_empty",    bus.empty,    1);

    // Fill and stream: a priming byte keeps the sender busy while 16 fill
    resp_dly = 25;
    put(8'hEE, 1'b1);
    for (int i = 0; i < 16; i++) put(8'(i), 1'b1);
    idle();
    chk("fill_full",  bus.full,  1);
    chk("fill_count", bus.count, 16);
    resp_dly  = 12;
    last_done = -1;
    gap_chk   = 1'b1;
    drain();
    gap_chk   = 1'b0;

    // Overflow: priming byte never acknowledged, then 17 writes
    skip_n = 1;
    put(8'hE1, 1'b1);
    for (int i = 0; i < 16; i++) put(8'(8'h10 + i), 1'b1);
    put(8'h2F, 1'b0);
    idle();
    chk("ovf_set",   bus.overflow, 1);
    chk("ovf_full",  bus.full,     1);
    chk("ovf_count", bus.count,    16);
    @(posedge clk);
    #1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h55;
    bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.wr_en   = 1'b0;
    bus.ovf_clr = 1'b0;
    chk("ovf_drop_wins_clr", bus.overflow, 1);
    chk("ovf_count_same",    bus.count,    16);
    @(posedge clk);
    #1 bus.ovf_clr = 1'b1;
    @(posedge clk);
    #1 bus.ovf_clr = 1'b0;
    chk("ovf_cleared", bus.overflow, 0);
    drain();
    chk("ovf_prime_timeout", errs, 1);

    // Timeout: first byte never acknowledged, second sent normally
    skip_n = 1;
    put(8'h3C, 1'b1);
    put(8'h3D, 1'b1);
    idle();
    drain();
    chk("timeout_errs", errs, 2);

    // Pointer wrap with interleaved writes and sends
    resp_dly = 3;
    cnt_chk  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      put(8'(8'h40 + i), 1'b1);
      idle();
      cycles(i % 5);
    end
    drain();
    cnt_chk  = 1'b0;
    resp_dly = 12;

    // Reset mid-WAIT with five bytes queued
    skip_n = 1;
    for (int i = 0; i < 6; i++) put(8'(8'h80 + i), 1'b1);
    idle();
    cycles(2);
    chk("pre_reset_count", bus.count, 5);
    sends_before = sends;
    @(posedge clk);
    #3 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_count",    bus.count,    0);
    chk("async_rst_empty",    bus.empty,    1);
    chk("async_rst_full",     bus.full,     0);
    chk("async_rst_overflow", bus.overflow, 0);
    chk("async_rst_txbyte",   bus.txbyte,   0);
    chk("async_rst_senddata", bus.senddata, 0);
    chk("async_rst_tx_err",   bus.tx_err,   0);
    skip_n = 0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    done_force = 1'b1;
    cycles(1);
    done_force = 1'b0;
    cycles(20);
    chk("stale_txdone_no_send", sends, sends_before);
    chk("post_reset_empty",     bus.empty, 1);

    // Every accepted byte sent exactly once before the reset test's flush
    chk("total_sends", sends, 78);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
